sd_cmd: RTL and testbench

- Serial SD command-line engine, directly downstream of the SD bus controller FSM.
- Consumes the FSM's start pulse, command index and argument. Serialises a 48-bit command frame onto the CMD line, then receives and checks the card response.
- Returns a one-cycle done strobe, a fail flag and the aligned response word that the FSM decodes (RCA, card status, CSD fields).
- Runs entirely in the SD-bus clock domain.

---
 rtl/sd_cmd_pkg.sv | 53 +++++
 rtl/sd_cmd_crc7.sv | 37 +++
 rtl/sd_cmd.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_cmd.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared definitions for the SD command-line engine.
//   - command index constants that change response handling
//   - response frame lengths
//   - CRC7 polynomial and a one-bit CRC7 step helper
//   - FSM state encoding and response-type encoding
package sd_cmd_pkg;

    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD9   = 6'd9;
    localparam logic [5:0] CMD15  = 6'd15;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] LEN_SHORT = 8'd48;
    localparam logic [7:0] LEN_LONG  = 8'd136;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_SHORT = 2'd1,
        RSP_LONG  = 2'd2
    } rsp_t;

    // Advance a CRC7 register by one message bit, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

    // Response class implied by a command index.
    function automatic rsp_t rsp_type(input logic [5:0] idx);
        rsp_t r;
        if ((idx == CMD2) || (idx == CMD9)) begin
            r = RSP_LONG;
        end else if (idx == CMD15) begin
            r = RSP_NONE;
        end else begin
            r = RSP_SHORT;
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_cmd_crc7.sv
// sd_crc7: serial CRC7 accumulator, shared by the transmit and receive paths.
// Ports:
//   iclk   - SD-bus clock
//   irst_n - asynchronous active-low reset
//   iclr   - synchronous clear (priority over ien)
//   ien    - absorb ibit this cycle
//   ibit   - message bit, MSB first
//   ocrc   - current CRC7 remainder
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       iclr,
    input  logic       ien,
    input  logic       ibit,
    output logic [6:0] ocrc
);

    logic [6:0] crc_r;

    // CRC register: clear, step or hold
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            crc_r <= 7'h00;
        end else if (iclr) begin
            crc_r <= 7'h00;
        end else if (ien) begin
            crc_r <= crc7_step(crc_r, ibit);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign ocrc = crc_r;

endmodule

// File: rtl/sd_cmd.sv
// sd_cmd: SD CMD-line engine. Sends a 48-bit command frame, then waits for,
// receives and checks the card response (48-bit or 136-bit), enforces an idle
// gap and reports completion.
// Ports:
//   iclk, irst_n      - SD-bus clock, asynchronous active-low reset
//   istart            - start request, honoured only in IDLE
//   iindex, iarg      - command index and argument, latched on accept
//   icmd              - CMD line from pad
//   ocmd, ocmd_oe     - CMD line drive value and output enable
//   odone             - one-cycle completion strobe
//   ofail             - timeout / CRC / index / end-bit error, valid with odone
//   oresp             - received frame bits [83:8], held until next accept
module sd_cmd
    import sd_cmd_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        istart,
    input  logic [5:0]  iindex,
    input  logic [31:0] iarg,
    input  logic        icmd,
    output logic        ocmd,
    output logic        ocmd_oe,
    output logic        odone,
    output logic        ofail,
    output logic [75:0] oresp
);

    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);
    localparam logic [7:0] NCC_LAST = 8'(NCC - 1);

    state_t        state_r, state_s;
    rsp_t          rsp_r, rsp_s;
    logic [7:0]    cnt_r, cnt_s;
    logic [5:0]    idx_r, idx_s;
    logic [31:0]   arg_r, arg_s;
    logic [83:0]   shreg_r, shreg_s;
    logic [75:0]   oresp_r, oresp_s;
    logic          ofail_r, ofail_s;
    logic          odone_r, odone_s;
    logic          ocmd_r, ocmd_s;
    logic          oe_r, oe_s;

    logic          crc_clr_s, crc_en_s, crc_bit_s;
    logic [6:0]    crc_s;
    logic [39:0]   tx_word_s;
    logic [6:0]    crc_word_s;
    logic [83:0]   shift_s;
    logic [7:0]    rx_n_s, len_s, crc_first_s, crc_last_s;
    logic          frame_err_s;

    sd_crc7 u_crc (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (crc_clr_s),
        .ien    (crc_en_s),
        .ibit   (crc_bit_s),
        .ocrc   (crc_s)
    );

    // Frame geometry and end-of-frame checks for the latched response type
    always_comb begin
        tx_word_s   = {2'b01, idx_r, arg_r} << cnt_r[5:0];
        crc_word_s  = crc_s << cnt_r[2:0];
        shift_s     = {shreg_r[82:0], icmd};
        rx_n_s      = cnt_r + 8'd1;
        len_s       = (rsp_r == RSP_LONG) ? LEN_LONG : LEN_SHORT;
        // R2 leaves its 8-bit header out of the CRC; short frames cover all 40 leading bits
        crc_first_s = (rsp_r == RSP_LONG) ? 8'd9 : 8'd1;
        crc_last_s  = len_s - 8'd8;
        frame_err_s = 1'b0;
        if (!shift_s[0]) begin
            frame_err_s = 1'b1;
        end else if ((rsp_r == RSP_SHORT) && (idx_r != ACMD41) && (shift_s[45:40] != idx_r)) begin
            frame_err_s = 1'b1;
        end else if ((idx_r != ACMD41) && (shift_s[7:1] != crc_s)) begin
            frame_err_s = 1'b1;
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        rsp_s     = rsp_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        arg_s     = arg_r;
        shreg_s   = shreg_r;
        oresp_s   = oresp_r;
        ofail_s   = ofail_r;
        odone_s   = 1'b0;
        ocmd_s    = 1'b1;
        oe_s      = 1'b0;
        crc_clr_s = 1'b0;
        crc_en_s  = 1'b0;
        crc_bit_s = icmd;
        case (state_r)
            ST_IDLE: begin
                // odone_r gates out a request arriving in the strobe cycle
                if (istart && !odone_r) begin
                    idx_s     = iindex;
                    arg_s     = iarg;
                    rsp_s     = rsp_type(iindex);
                    oresp_s   = 76'd0;
                    ofail_s   = 1'b0;
                    shreg_s   = 84'd0;
                    cnt_s     = 8'd1;
                    ocmd_s    = 1'b0;
                    oe_s      = 1'b1;
                    // start bit is 0, so clearing instead of absorbing it is equivalent
                    crc_clr_s = 1'b1;
                    state_s   = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_r == LEN_SHORT) begin
                    cnt_s     = 8'd0;
                    crc_clr_s = 1'b1;
                    state_s   = (rsp_r == RSP_NONE) ? ST_GAP : ST_WAIT;
                end else begin
                    oe_s  = 1'b1;
                    cnt_s = cnt_r + 8'd1;
                    if (cnt_r < 8'd40) begin
                        ocmd_s    = tx_word_s[39];
                        crc_en_s  = 1'b1;
                        crc_bit_s = tx_word_s[39];
                    end else if (cnt_r < 8'd47) begin
                        ocmd_s = crc_word_s[6];
                    end else begin
                        ocmd_s = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!icmd) begin
                    // start bit is received bit 1
                    shreg_s  = shift_s;
                    cnt_s    = 8'd1;
                    crc_en_s = (crc_first_s == 8'd1);
                    state_s  = ST_RECV;
                end else if (cnt_r == NCR_LAST) begin
                    ofail_s = 1'b1;
                    cnt_s   = 8'd0;
                    state_s = ST_GAP;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_RECV: begin
                shreg_s  = shift_s;
                cnt_s    = rx_n_s;
                crc_en_s = (rx_n_s >= crc_first_s) && (rx_n_s <= crc_last_s);
                if (rx_n_s == len_s) begin
                    oresp_s = shift_s[83:8];
                    ofail_s = ofail_r | frame_err_s;
                    cnt_s   = 8'd0;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_GAP: begin
                if (cnt_r == NCC_LAST) begin
                    odone_s = 1'b1;
                    cnt_s   = 8'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                cnt_s   = 8'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= ST_IDLE;
            rsp_r   <= RSP_NONE;
            cnt_r   <= 8'd0;
            idx_r   <= 6'd0;
            arg_r   <= 32'd0;
            shreg_r <= 84'd0;
            oresp_r <= 76'd0;
            ofail_r <= 1'b0;
            odone_r <= 1'b0;
            ocmd_r  <= 1'b1;
            oe_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            rsp_r   <= rsp_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            arg_r   <= arg_s;
            shreg_r <= shreg_s;
            oresp_r <= oresp_s;
            ofail_r <= ofail_s;
            odone_r <= odone_s;
            ocmd_r  <= ocmd_s;
            oe_r    <= oe_s;
        end
    end

    assign ocmd    = ocmd_r;
    assign ocmd_oe = oe_r;
    assign odone   = odone_r;
    assign ofail   = ofail_r;
    assign oresp   = oresp_r;

endmodule

// File: tb/tb_sd_cmd.sv
// tb_sd_cmd: self-checking bench for sd_cmd with a card model on the CMD line.
module tb_sd_cmd;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        istart = 1'b0;
    logic [5:0]  iindex = 6'd0;
    logic [31:0] iarg = 32'd0;
    logic        icmd = 1'b1;
    logic        ocmd, ocmd_oe, odone, ofail;
    logic [75:0] oresp;

    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    sd_cmd #(.NCR_MAX(64), .NCC(8)) dut (
        .iclk(iclk), .irst_n(irst_n), .istart(istart), .iindex(iindex),
        .iarg(iarg), .icmd(icmd), .ocmd(ocmd), .ocmd_oe(ocmd_oe),
        .odone(odone), .ofail(ofail), .oresp(oresp)
    );

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        int           k;
        logic [135:0] f;
        int           len;
        logic [47:0]  exp_tx;
        logic         exp_fail;
        int           exp_done;
        logic [75:0]  mask;
        logic [75:0]  val;
    } vec_t;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 mod (x^7+x^3+1), M = v[hi:lo], by long division
    function automatic logic [6:0] crc_ref(input logic [135:0] v, input int hi, input int lo);
        logic [142:0] d;
        d = '0;
        for (int i = hi; i >= lo; i--) d[i - lo + 7] = v[i];
        for (int i = hi - lo + 7; i >= 7; i--)
            if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
        return d[6:0];
    endfunction

    function automatic logic [47:0] tx_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] v;
        v = '0;
        v[39:0] = {2'b01, idx, arg};
        return {2'b01, idx, arg, crc_ref(v, 39, 0), 1'b1};
    endfunction

    function automatic int rsp_len(input logic [5:0] idx);
        if (idx == 6'd2 || idx == 6'd9) return 136;
        if (idx == 6'd15) return 0;
        return 48;
    endfunction

    function automatic logic [135:0] short_frame(input logic [5:0] fld, input logic [31:0] pay);
        logic [135:0] f;
        f = '0;
        f[47:0] = {2'b00, fld, pay, 7'h00, 1'b1};
        f[7:1] = crc_ref(f, 47, 8);
        return f;
    endfunction

    function automatic logic [135:0] long_frame(input logic [127:0] csd);
        logic [135:0] f;
        f = {2'b00, 6'h3F, csd[127:8], 7'h00, 1'b1};
        f[7:1] = crc_ref(f, 127, 8);
        return f;
    endfunction

    // Response-check rules applied to a complete received frame
    function automatic logic model_fail(input logic [5:0] idx, input logic [135:0] f, input int len);
        if (!f[0]) return 1'b1;
        if (len == 48) begin
            if (idx != 6'd41 && f[45:40] != idx) return 1'b1;
            if (idx != 6'd41 && crc_ref(f, 47, 8) != f[7:1]) return 1'b1;
        end else begin
            if (crc_ref(f, 127, 8) != f[7:1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One transaction; card answers k idle clocks after the end bit (k>=64: silent)
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int k,
                           input logic [135:0] f, input int len, input int poke,
                           output int done_cyc, output logic fail_o, output logic [75:0] resp_o,
                           output logic [47:0] tx_o, output int oe_cnt);
        int last_oe, rs;
        bit done;
        iindex = idx; iarg = arg; istart = 1'b1;
        tx_o = '0; oe_cnt = 0; last_oe = -1; rs = -1; done = 0;
        done_cyc = -1; fail_o = 1'b0; resp_o = '0;
        for (int e = 0; e < 400 && !done; e++) begin
            @(posedge iclk); #1;
            istart = (e + 1 == poke);
            if (ocmd_oe) begin
                tx_o = {tx_o[46:0], ocmd};
                oe_cnt++;
                last_oe = e + 1;
            end
            if (!ocmd_oe && last_oe > 0 && rs < 0 && len > 0 && k < 64) rs = last_oe + 1 + k;
            if (rs > 0 && e + 1 >= rs && e + 1 < rs + len) icmd = f[len - 1 - (e + 1 - rs)];
            else icmd = 1'b1;
            if (odone) begin
                done = 1;
                done_cyc = e + 1;
                fail_o = ofail;
                resp_o = oresp;
            end
        end
        istart = 1'b0;
        icmd = 1'b1;
    endtask

    task automatic verify(input string nm, input vec_t v, input int poke, input bit pulse_chk);
        int dc, oc;
        logic fl;
        logic [75:0] rp, er;
        logic [47:0] tx;
        logic [135:0] sh;
        run_cmd(v.idx, v.arg, v.k, v.f, v.len, poke, dc, fl, rp, tx, oc);
        sh = v.f >> 8;
        er = (v.len == 0 || v.k >= 64) ? 76'd0 : sh[75:0];
        check({nm, "_tx"}, tx, v.exp_tx);
        check({nm, "_oe_cycles"}, oc, 48);
        check({nm, "_done_cycle"}, dc, v.exp_done);
        check({nm, "_fail"}, fl, v.exp_fail);
        check({nm, "_resp"}, rp, er);
        if (v.mask != 76'd0) check({nm, "_field"}, rp & v.mask, v.val);
        if (pulse_chk) begin
            @(posedge iclk); #1;
            check({nm, "_done_pulse"}, odone, 1'b0);
        end
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        logic [127:0] csd;
        int cnt, dseen;

        // reset state
        repeat (3) @(posedge iclk);
        #1;
        check("rst_ocmd", ocmd, 1'b1);
        check("rst_oe", ocmd_oe, 1'b0);
        check("rst_done", odone, 1'b0);
        check("rst_fail", ofail, 1'b0);
        check("rst_resp", oresp, 76'd0);
        irst_n = 1'b1;
        @(posedge iclk); #1;

        csd = '0;
        csd[83:80] = 4'd9;
        csd[73:62] = 12'hFFF;
        csd[49:47] = 3'd7;
        csd[127:126] = 2'b01;

        tbl[0] = '{6'd8, 32'h000001AA, 2, short_frame(6'd8, 32'h000001AA), 48,
                   48'h48000001AA87, 1'b0, 107, 76'hFFFFFFFF, 76'h1AA};
        tbl[1] = '{6'd55, 32'h0, 5, short_frame(6'd55, 32'h120), 48,
                   48'h770000000065, 1'b0, 110, 76'h120, 76'h120};
        tbl[2] = tbl[1];
        tbl[2].f = tbl[1].f ^ 136'h8;
        tbl[2].exp_fail = 1'b1;
        tbl[2].mask = 76'd0;
        tbl[3] = '{6'd9, 32'h00010000, 1, long_frame(csd), 136,
                   tx_frame(6'd9, 32'h00010000), 1'b0, 194,
                   (76'hF << 72) | (76'hFFF << 54) | (76'h7 << 39),
                   (76'h9 << 72) | (76'hFFF << 54) | (76'h7 << 39)};
        tbl[4] = '{6'd41, 32'h80300000, 3, {88'd0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, 48,
                   tx_frame(6'd41, 32'h80300000), 1'b0, 108, 76'h80000000, 76'h80000000};
        tbl[5] = '{6'd13, 32'h00010000, 64, 136'd0, 48,
                   tx_frame(6'd13, 32'h00010000), 1'b1, 121, 76'd0, 76'd0};
        tbl[6] = '{6'd15, 32'h00010000, 0, 136'd0, 0,
                   tx_frame(6'd15, 32'h00010000), 1'b0, 57, 76'd0, 76'd0};
        tbl[7] = '{6'd17, 32'h00000200, 63, short_frame(6'd17, 32'h00000900), 48,
                   tx_frame(6'd17, 32'h00000200), 1'b0, 168, 76'd0, 76'd0};
        tbl[8] = tbl[7];
        tbl[8].k = 0;
        tbl[8].exp_done = 105;
        tbl[8].f = tbl[7].f ^ 136'h1;
        tbl[8].exp_fail = 1'b1;
        tbl[9] = tbl[8];
        tbl[9].f = short_frame(6'd18, 32'h00000900);

        for (int i = 0; i < 10; i++) verify($sformatf("tbl%0d", i), tbl[i], -1, 1'b1);

        // istart pulsed during RECV is ignored
        rv = tbl[8];
        rv.k = 4; rv.exp_done = 109; rv.f = short_frame(6'd17, 32'hCAFE0000); rv.exp_fail = 1'b0;
        verify("start_in_recv", rv, 49 + 4 + 10, 1'b0);

        // istart in the odone cycle is ignored, accepted one cycle later
        istart = 1'b1; iindex = 6'd15; iarg = 32'h0;
        @(posedge iclk); #1;
        check("start_in_done_ignored", ocmd_oe, 1'b0);
        @(posedge iclk); #1;
        istart = 1'b0;
        check("start_after_done_oe", ocmd_oe, 1'b1);
        check("start_after_done_bit", ocmd, 1'b0);
        cnt = 1;
        while (!odone && cnt < 200) begin
            @(posedge iclk); #1;
            cnt++;
        end
        check("late_start_done_cycle", cnt, 57);
        @(posedge iclk); #1;

        // asynchronous reset while bit 20 is on the line
        iindex = 6'd17; iarg = 32'h12345678; istart = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge iclk); #1;
            istart = 1'b0;
        end
        check("pre_reset_oe", ocmd_oe, 1'b1);
        #2 irst_n = 1'b0;
        #1;
        check("async_oe_release", ocmd_oe, 1'b0);
        check("async_ocmd_idle", ocmd, 1'b1);
        @(posedge iclk); #1;
        irst_n = 1'b1;
        dseen = 0;
        for (int e = 0; e < 150; e++) begin
            @(posedge iclk); #1;
            if (odone || ocmd_oe) dseen++;
        end
        check("reset_no_done", dseen, 0);
        verify("post_reset", tbl[6], -1, 1'b1);

        // randomized transactions against the reference rules
        for (int n = 0; n < 30; n++) begin
            rv.idx = 6'($urandom_range(0, 63));
            rv.arg = $urandom;
            rv.len = rsp_len(rv.idx);
            rv.k = $urandom_range(0, 70);
            if (rv.idx == 6'd41)
                rv.f = {88'd0, 2'b00, 6'h3F, 32'($urandom), 7'h7F, 1'b1};
            else if (rv.len == 136)
                rv.f = long_frame({$urandom, $urandom, $urandom, $urandom});
            else
                rv.f = short_frame(rv.idx, $urandom);
            if (rv.len > 0 && $urandom_range(0, 2) == 0)
                rv.f[$urandom_range(0, rv.len - 2)] ^= 1'b1;
            rv.exp_tx = tx_frame(rv.idx, rv.arg);
            rv.mask = 76'd0; rv.val = 76'd0;
            if (rv.len == 0) begin
                rv.exp_done = 57; rv.exp_fail = 1'b0;
            end else if (rv.k >= 64) begin
                rv.exp_done = 121; rv.exp_fail = 1'b1;
            end else begin
                rv.exp_done = 57 + rv.k + rv.len;
                rv.exp_fail = model_fail(rv.idx, rv.f, rv.len);
            end
            verify($sformatf("rnd%0d_cmd%0d", n, rv.idx), rv, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
